// File: rtl/cpu_dump_ctrl_pkg.sv
// rtl/cpu_dump_ctrl_pkg.sv - state encoding, tag values and default sizes for the debug-dump sequencer
package cpu_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAITQ = 3'd1,
    ST_REGS  = 3'd2,
    ST_MEMS  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } dump_state_t;

  localparam logic TAG_REG = 1'b0;
  localparam logic TAG_MEM = 1'b1;

  localparam int DEF_REG_COUNT = 32;
  localparam int DEF_MEM_WORDS = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_IDX_W     = 5;

endpackage

// File: rtl/dump_out_slot.sv
// rtl/dump_out_slot.sv - single-entry valid/ready output register for dump words
module dump_out_slot #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_tag,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              tag,
  output logic [IDX_W-1:0]  idx
);

  // The sequencer only raises load when the slot is empty or being accepted,
  // so a load never overwrites an unaccepted word.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      tag   <= 1'b0;
      idx   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      tag   <= load_tag;
      idx   <= load_idx;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_dump_ctrl.sv
// rtl/cpu_dump_ctrl.sv - debug-dump sequencer: stalls the CPU, streams RF then DM words out
// CPU_DUMP_MEM_EN enables the data-memory pass; without it only registers are dumped.
module cpu_dump_ctrl
  import cpu_dump_pkg::*;
#(
  parameter int REG_COUNT = DEF_REG_COUNT,
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              cpu_quiet_i,
  output logic              cpu_stall_o,
  output logic [IDX_W-1:0]  rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic [IDX_W-1:0]  dm_raddr_o,
  input  logic [DATA_W-1:0] dm_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_tag_o,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
`ifdef CPU_DUMP_MEM_EN
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);
`endif

  dump_state_t       state;
  logic [IDX_W-1:0]  idx;
  logic              quiet_q;
  logic              slot_free;
  logic              load;
  logic              load_tag;
  logic [DATA_W-1:0] load_data;

  assign slot_free = !dump_valid_o || dump_ready_i;

  always_comb begin
    load      = slot_free && (state == ST_REGS || state == ST_MEMS);
    load_tag  = (state == ST_MEMS) ? TAG_MEM : TAG_REG;
    load_data = rf_rdata_i;
`ifdef CPU_DUMP_MEM_EN
    if (state == ST_MEMS) load_data = dm_rdata_i;
`endif
  end

  assign rf_raddr_o = (state == ST_REGS) ? idx : '0;
`ifdef CPU_DUMP_MEM_EN
  assign dm_raddr_o = (state == ST_MEMS) ? idx : '0;
`else
  logic unused_mem;
  assign unused_mem = ^{dm_rdata_i, 32'(MEM_WORDS)};
  assign dm_raddr_o = '0;
`endif

  // Quiet must be seen on one WAITQ edge and acted on the next, giving the
  // pipeline a full frozen cycle before the read ports are taken over.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      quiet_q     <= 1'b0;
      cpu_stall_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      quiet_q <= (state == ST_WAITQ) && cpu_quiet_i;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state       <= ST_WAITQ;
            cpu_stall_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        ST_WAITQ: begin
          if (quiet_q) begin
            state <= ST_REGS;
            idx   <= '0;
          end
        end
        ST_REGS: begin
          if (slot_free) begin
            if (idx == REG_LAST) begin
              idx <= '0;
`ifdef CPU_DUMP_MEM_EN
              state <= ST_MEMS;
`else
              state <= ST_DRAIN;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
`ifdef CPU_DUMP_MEM_EN
        ST_MEMS: begin
          if (slot_free) begin
            if (idx == MEM_LAST) begin
              idx   <= '0;
              state <= ST_DRAIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
`endif
        ST_DRAIN: begin
          if (dump_valid_o && dump_ready_i) begin
            state       <= ST_DONE;
            cpu_stall_o <= 1'b0;
            done_o      <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          cpu_stall_o <= 1'b0;
          busy_o      <= 1'b0;
          done_o      <= 1'b0;
        end
      endcase
    end
  end

  dump_out_slot #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_slot (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .load     (load),
    .load_data(load_data),
    .load_tag (load_tag),
    .load_idx (idx),
    .ready    (dump_ready_i),
    .valid    (dump_valid_o),
    .data     (dump_data_o),
    .tag      (dump_tag_o),
    .idx      (dump_idx_o)
  );

endmodule

// File: tb/tb_cpu_dump_ctrl.sv
// tb/tb_cpu_dump_ctrl.sv - directed self-checking bench for cpu_dump_ctrl
// Expected counts follow CPU_DUMP_MEM_EN as seen by this compile.
module tb_cpu_dump_ctrl;

`ifdef CPU_DUMP_MEM_EN
  localparam int NWORDS   = 64;
  localparam int DONE_REL = 67;
  localparam logic ABORT_TAG = 1'b1;
`else
  localparam int NWORDS   = 32;
  localparam int DONE_REL = 35;
  localparam logic ABORT_TAG = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        cpu_quiet_i = 1'b1;
  logic        cpu_stall_o;
  logic [4:0]  rf_raddr_o;
  logic [31:0] rf_rdata_i;
  logic [4:0]  dm_raddr_o;
  logic [31:0] dm_rdata_i;
  logic        dump_valid_o;
  logic        dump_ready_i = 1'b1;
  logic [31:0] dump_data_o;
  logic        dump_tag_o;
  logic [4:0]  dump_idx_o;
  logic        busy_o;
  logic        done_o;

  logic [31:0] rf [32];
  logic [31:0] dm [32];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  assign rf_rdata_i = rf[rf_raddr_o];
  assign dm_rdata_i = dm[dm_raddr_o];

  cpu_dump_ctrl dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .cpu_quiet_i (cpu_quiet_i),
    .cpu_stall_o (cpu_stall_o),
    .rf_raddr_o  (rf_raddr_o),
    .rf_rdata_i  (rf_rdata_i),
    .dm_raddr_o  (dm_raddr_o),
    .dm_rdata_i  (dm_rdata_i),
    .dump_valid_o(dump_valid_o),
    .dump_ready_i(dump_ready_i),
    .dump_data_o (dump_data_o),
    .dump_tag_o  (dump_tag_o),
    .dump_idx_o  (dump_idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] exp_word(input int w);
    logic [31:0] d;
    logic        t;
    logic [4:0]  i;
    t = (w >= 32);
    i = 5'(w % 32);
    d = t ? 32'(100 + (w - 32)) : 32'(3 * w);
    return {t, i, d};
  endfunction

  task automatic run_dump(input int q_low, input bit rdy_toggle, input bit start_glitch,
                          input bit abort, input string name);
    int n, done_rel, done_cnt, first_valid, stall_bad, hold, dm_bad, bad_order, nw;
    bit finished;
    done_rel = -1; done_cnt = 0; first_valid = -1; stall_bad = 0;
    hold = 0; dm_bad = 0; bad_order = 0; nw = 0; finished = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    cpu_quiet_i = (q_low == 0);
    @(negedge clk_i);
    start_i = 1'b0;
    n = cyc;
    check({name, " busy after start"}, {63'd0, busy_o}, 64'd1);
    check({name, " stall after start"}, {63'd0, cpu_stall_o}, 64'd1);
    for (int k = 0; k < 250; k++) begin
      cpu_quiet_i = (k >= q_low);
      start_i = start_glitch && (k == 10);
      if (abort && dump_valid_o && dump_tag_o == ABORT_TAG && dump_idx_o == 5'd10) begin
        rst_n = 1'b0;
        #1;
        check({name, " valid"}, {63'd0, dump_valid_o}, 64'd0);
        check({name, " stall"}, {63'd0, cpu_stall_o}, 64'd0);
        check({name, " busy/done"}, {62'd0, busy_o, done_o}, 64'd0);
        check({name, " data/tag/idx"}, {26'd0, dump_tag_o, dump_idx_o, dump_data_o}, 64'd0);
        check({name, " addresses"}, {54'd0, rf_raddr_o, dm_raddr_o}, 64'd0);
        @(negedge clk_i);
        check({name, " no done"}, {63'd0, done_o}, 64'd0);
        rst_n = 1'b1;
        return;
      end
      if (rdy_toggle && dump_valid_o && dump_tag_o == 1'b0 && dump_idx_o == 5'd4 && hold < 2) begin
        dump_ready_i = 1'b0;
        check({name, " held word"}, {26'd0, dump_tag_o, dump_idx_o, dump_data_o}, 64'd4 << 32 | 64'd12);
        hold++;
      end else begin
        dump_ready_i = 1'b1;
      end
      if (dump_valid_o && first_valid < 0) first_valid = k;
      if (dump_valid_o && dump_ready_i) begin
        if ({dump_tag_o, dump_idx_o, dump_data_o} !== exp_word(nw)) begin
          if (bad_order == 0)
            $display("FAIL %s word %0d: got tag %0d idx %0d data %0d", name, nw,
                     dump_tag_o, dump_idx_o, dump_data_o);
          bad_order++;
        end
        nw++;
      end
      if (done_o) begin
        done_cnt++;
        if (done_rel < 0) done_rel = k;
      end
      if (!cpu_stall_o && done_rel < 0) stall_bad++;
`ifndef CPU_DUMP_MEM_EN
      if (dm_raddr_o != 5'd0) dm_bad++;
`endif
      if (done_rel >= 0 && k == done_rel + 1) begin
        check({name, " idle after done"}, {62'd0, busy_o, cpu_stall_o}, 64'd0);
        finished = 1;
        break;
      end
      @(negedge clk_i);
    end
    dump_ready_i = 1'b1;
    cpu_quiet_i = 1'b1;
    if (abort) check({name, " abort point reached"}, 64'd0, 64'd1);
    check({name, " finished in budget"}, {63'd0, finished}, 64'd1);
    check({name, " first valid"}, 64'(first_valid), 64'(3 + q_low));
    check({name, " done cycle"}, 64'(done_rel), 64'(DONE_REL + q_low + (rdy_toggle ? 2 : 0)));
    check({name, " done pulses"}, 64'(done_cnt), 64'd1);
    check({name, " word count"}, 64'(nw), 64'(NWORDS));
    check({name, " order errors"}, 64'(bad_order), 64'd0);
    check({name, " stall gaps"}, 64'(stall_bad), 64'd0);
    check({name, " dm addr"}, 64'(dm_bad), 64'd0);
    if (rdy_toggle) check({name, " hold cycles"}, 64'(hold), 64'd2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'(i * 3);
      dm[i] = 32'(100 + i);
    end
    repeat (3) @(negedge clk_i);
    check("reset valid/stall", {62'd0, dump_valid_o, cpu_stall_o}, 64'd0);
    check("reset busy/done", {62'd0, busy_o, done_o}, 64'd0);
    check("reset data/tag/idx", {26'd0, dump_tag_o, dump_idx_o, dump_data_o}, 64'd0);
    check("reset addresses", {54'd0, rf_raddr_o, dm_raddr_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk_i);
    run_dump(0, 0, 0, 0, "base");
    run_dump(5, 0, 0, 0, "quiet");
    run_dump(0, 1, 0, 0, "ready");
    run_dump(0, 0, 1, 0, "restart");
    run_dump(0, 0, 0, 1, "abort");
    run_dump(0, 0, 0, 0, "fresh");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
